morse_seq_encoder: RTL and testbench

//  Parametrised successor to the single-digit Morse lookup. Scans NUM_CH seven-segment

---
 rtl/morse_seq_encoder_if.sv | 30 +++
 rtl/morse_seq_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_morse_seq_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_seq_encoder_if.sv
// Digit-store side bus of the Morse sequence encoder: request/pause controls,
// the slot snapshot inputs and the key/status outputs.
interface morse_seq_encoder_if #(
  parameter int NUM_CH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              en;
  logic              start;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH*8-1:0] seg_in;
  logic              morse_out;
  logic [4:0]        morse_code;
  logic [CH_W-1:0]   cur_ch;
  logic              busy;
  logic              done;
  logic              err;

  // Controller / digit store side.
  modport master (
    output en, start, ch_en, seg_in,
    input  morse_out, morse_code, cur_ch, busy, done, err
  );

  // Encoder side.
  modport slave (
    input  en, start, ch_en, seg_in,
    output morse_out, morse_code, cur_ch, busy, done, err
  );
endinterface

// File: rtl/morse_seq_encoder.sv
// Morse sequence encoder: snapshots NUM_CH seven-segment slots on start,
// decodes each enabled non-blank slot to its 5-symbol digit code and keys it
// out with dot/dash/space/gap timing counted in units of UNIT_CYCLES clocks.
// en=0 freezes every counter and state bit (pause).
module morse_seq_encoder #(
  parameter int NUM_CH      = 8,
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  morse_seq_encoder_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MARK, S_SPACE, S_GAP, S_DONE
  } state_t;

  // Active-low segment pattern (dp stripped) -> {valid, digit}.
  function automatic logic [4:0] f_digit(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b1, 4'd0};
      7'h79:   return {1'b1, 4'd1};
      7'h24:   return {1'b1, 4'd2};
      7'h30:   return {1'b1, 4'd3};
      7'h19:   return {1'b1, 4'd4};
      7'h12:   return {1'b1, 4'd5};
      7'h02:   return {1'b1, 4'd6};
      7'h78:   return {1'b1, 4'd7};
      7'h00:   return {1'b1, 4'd8};
      7'h10:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // Digit -> Morse code, bit 4 is the first symbol, 1 = dash.
  function automatic logic [4:0] f_code(input logic [3:0] d);
    if (d == 4'd0)      return 5'b11111;
    else if (d <= 4'd5) return 5'b11111 >> d;
    else                return ~(5'b11111 >> (d - 4'd5));
  endfunction

  state_t              r_state,   w_state_nxt;
  logic [CYC_W-1:0]    r_cyc,     w_cyc_nxt;
  logic [1:0]          r_unit,    w_unit_nxt;
  logic [2:0]          r_sym,     w_sym_nxt;
  logic [NUM_CH-1:0]   r_pending, w_pending_nxt;
  logic [NUM_CH*8-1:0] r_seg,     w_seg_nxt;
  logic [4:0]          r_code,    w_code_nxt;
  logic [CH_W-1:0]     r_ch,      w_ch_nxt;
  logic                r_err,     w_err_nxt;

  logic            w_found;
  logic [CH_W-1:0] w_pick;
  logic [7:0]      w_pick_seg;
  logic            w_valid;
  logic            w_blank;
  logic [3:0]      w_digit;
  logic [4:0]      w_new_code;
  logic            w_dash;
  logic            w_timed;
  logic [1:0]      w_last_unit;
  logic            w_unit_end;
  logic            w_seg_end;
  logic            w_unused_dp;

  // Lowest-index pending slot and the decode of its snapshot pattern.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(k);
      end
    end
    w_pick_seg           = r_seg[{w_pick, 3'b000} +: 8];
    {w_valid, w_digit}   = f_digit(w_pick_seg[6:0]);
    w_blank              = (w_pick_seg[6:0] == 7'h7F);
    w_new_code           = f_code(w_digit);
  end

  // The decimal point carries no digit information.
  assign w_unused_dp = w_pick_seg[7];

  // Segment timing: which unit ends the current mark/space/gap.
  always_comb begin
    w_dash      = r_code[3'd4 - r_sym];
    w_timed     = (r_state == S_MARK) || (r_state == S_SPACE) || (r_state == S_GAP);
    w_last_unit = 2'd0;
    if ((r_state == S_MARK && w_dash) || r_state == S_GAP) w_last_unit = 2'd2;
    w_unit_end  = bus.en && (r_cyc == CYC_LAST);
    w_seg_end   = w_timed && w_unit_end && (r_unit == w_last_unit);
  end

  // Next-state, counter and snapshot logic; nothing moves while en=0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = r_cyc;
    w_unit_nxt    = r_unit;
    w_sym_nxt     = r_sym;
    w_pending_nxt = r_pending;
    w_seg_nxt     = r_seg;
    w_code_nxt    = r_code;
    w_ch_nxt      = r_ch;
    w_err_nxt     = r_err;

    if (w_timed && bus.en) begin
      if (w_unit_end) begin
        w_cyc_nxt  = '0;
        w_unit_nxt = w_seg_end ? 2'd0 : r_unit + 2'd1;
      end else begin
        w_cyc_nxt = r_cyc + CYC_W'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        if (bus.en && bus.start) begin
          w_pending_nxt = bus.ch_en;
          w_seg_nxt     = bus.seg_in;
          w_err_nxt     = 1'b0;
          w_state_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.en) begin
          if (!w_found) begin
            w_state_nxt = S_DONE;
          end else begin
            w_pending_nxt[w_pick] = 1'b0;
            if (w_valid) begin
              w_ch_nxt    = w_pick;
              w_code_nxt  = w_new_code;
              w_sym_nxt   = 3'd0;
              w_state_nxt = S_MARK;
            end else if (!w_blank) begin
              w_err_nxt = 1'b1;
            end
          end
        end
      end
      S_MARK: begin
        if (w_seg_end) begin
          if (r_sym != 3'd4)   w_state_nxt = S_SPACE;
          else if (|r_pending) w_state_nxt = S_GAP;
          else                 w_state_nxt = S_DONE;
        end
      end
      S_SPACE: begin
        if (w_seg_end) begin
          w_sym_nxt   = r_sym + 3'd1;
          w_state_nxt = S_MARK;
        end
      end
      S_GAP: begin
        if (w_seg_end) w_state_nxt = S_LOAD;
      end
      S_DONE: begin
        if (bus.en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_unit    <= '0;
      r_sym     <= '0;
      r_pending <= '0;
      // NOTE: the slot snapshot is reset as well; it is only NUM_CH bytes and
      // a known value keeps X out of the decode path after reset.
      r_seg     <= '0;
      r_code    <= '0;
      r_ch      <= '0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_cyc     <= w_cyc_nxt;
      r_unit    <= w_unit_nxt;
      r_sym     <= w_sym_nxt;
      r_pending <= w_pending_nxt;
      r_seg     <= w_seg_nxt;
      r_code    <= w_code_nxt;
      r_ch      <= w_ch_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.morse_out  = (r_state == S_MARK);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE) && bus.en;
  assign bus.morse_code = r_code;
  assign bus.cur_ch     = r_ch;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_morse_seq_encoder.sv
// Bench for morse_seq_encoder: a timeline model built from the Morse rules is
// compared against the 8-slot DUT on every falling edge, and literal run-length
// strings pin the model. A 4-slot build is checked with literal values only.
module tb_morse_seq_encoder;
  localparam int N = 8;
  localparam int U = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_seq_encoder_if #(.NUM_CH(N)) bus8 ();
  morse_seq_encoder_if #(.NUM_CH(4)) bus4 ();

  morse_seq_encoder #(.NUM_CH(N), .UNIT_CYCLES(U)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  morse_seq_encoder #(.NUM_CH(4), .UNIT_CYCLES(U)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct packed {
    logic       mo;
    logic [4:0] code;
    logic [2:0] ch;
    logic       busy;
    logic       is_done;
    logic       err;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done8  = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   bank   = 1'b0;
  bit   active = 1'b0;
  int   idx    = 0;
  logic [4:0] h_code = '0;
  logic [2:0] h_ch   = '0;
  bit   rec8[$];
  bit   rec4[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, req);
    end
  endtask

  // Segment table: -1 blank, -2 unknown, else the digit.
  function automatic int m_digit(input logic [7:0] s);
    case (s[6:0])
      7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
      7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
      7'h00: return 8;  7'h10: return 9;  7'h7F: return -1;
      default: return -2;
    endcase
  endfunction

  // Textbook Morse digits, first symbol leftmost.
  function automatic logic [4:0] m_code(input int d);
    string p;
    logic [4:0] c;
    case (d)
      0: p = "-----"; 1: p = ".----"; 2: p = "..---"; 3: p = "...--"; 4: p = "....-";
      5: p = "....."; 6: p = "-...."; 7: p = "--..."; 8: p = "---.."; default: p = "----.";
    endcase
    for (int i = 0; i < 5; i++) c[4-i] = (p[i] == "-");
    return c;
  endfunction

  function automatic exp_t cur_entry(input int i);
    if (bank) return q1[i];
    return q0[i];
  endfunction

  function automatic int last_idx();
    if (bank) return q1.size() - 1;
    return q0.size() - 1;
  endfunction

  // Expected outputs, one entry per en=1 clock from the accepting edge on.
  task automatic build(input logic [N-1:0] mask, input logic [N*8-1:0] segs);
    exp_t t[$];
    exp_t e;
    int d;
    bit fin;
    logic [4:0] c;
    e = '{mo: 1'b0, code: h_code, ch: h_ch, busy: 1'b1, is_done: 1'b0, err: 1'b0};
    t.push_back(e);                         // slot pick cycle
    fin = 1'b0;
    for (int s = 0; s < N && !fin; s++) begin
      if (mask[s]) begin
        d = m_digit(segs[8*s +: 8]);
        if (d < 0) begin
          if (d == -2) e.err = 1'b1;
          t.push_back(e);                   // skipped: another pick cycle
        end else begin
          c = m_code(d);
          e.code = c;
          e.ch   = 3'(s);
          for (int y = 0; y < 5; y++) begin
            e.mo = 1'b1;
            repeat ((c[4-y] ? 3 : 1) * U) t.push_back(e);
            e.mo = 1'b0;
            if (y < 4) repeat (U) t.push_back(e);
          end
          if ((mask >> (s + 1)) != 0) begin
            repeat (3 * U) t.push_back(e);  // inter-character gap
            t.push_back(e);                 // next pick cycle
          end else begin
            fin = 1'b1;
          end
        end
      end
    end
    e.mo = 1'b0;
    e.is_done = 1'b1;
    t.push_back(e);
    e.is_done = 1'b0;
    e.busy = 1'b0;
    t.push_back(e);
    h_code = e.code;
    h_ch   = e.ch;
    if (bank) q0 = t;
    else      q1 = t;
  endtask

  // Model timeline pointer: restarts on an accepted start, advances on en=1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      idx    <= 0;
    end else if (bus8.en && bus8.start && (!active || idx == last_idx())) begin
      active <= 1'b1;
      idx    <= 0;
      bank   <= ~bank;
    end else if (active && bus8.en && idx < last_idx()) begin
      idx <= idx + 1;
    end
  end

  // Compare every output of the 8-slot DUT against the model each cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (!rst) begin
      if (active) e = cur_entry(idx);
      else        e = '0;
      check("morse_out",  32'(bus8.morse_out),  32'(e.mo));
      check("busy",       32'(bus8.busy),       32'(e.busy));
      check("done",       32'(bus8.done),       32'(e.is_done & bus8.en));
      check("morse_code", 32'(bus8.morse_code), 32'(e.code));
      check("cur_ch",     32'(bus8.cur_ch),     32'(e.ch));
      check("err",        32'(bus8.err),        32'(e.err));
      rec8.push_back(bus8.morse_out);
      rec4.push_back(bus4.morse_out);
      if (bus8.done) n_done8++;
    end
  end

  // Run lengths of the key signal from first to last mark, e.g. "2,2,6".
  function automatic string runs_str(input bit sel);
    bit q[$];
    string s;
    int first, last, n;
    bit cur;
    if (sel) q = rec4;
    else     q = rec8;
    first = -1;
    last  = -1;
    foreach (q[i]) if (q[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    if (first < 0) return "none";
    s = "";
    n = 0;
    cur = 1'b1;
    for (int i = first; i <= last; i++) begin
      if (q[i] == cur) n++;
      else begin
        if (s != "") s = {s, ","};
        s = {s, $sformatf("%0d", n)};
        cur = q[i];
        n = 1;
      end
    end
    if (s != "") s = {s, ","};
    s = {s, $sformatf("%0d", n)};
    return s;
  endfunction

  function automatic int span8();
    int first, last;
    first = -1;
    last  = -1;
    foreach (rec8[i]) if (rec8[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    return (first < 0) ? 0 : last - first + 1;
  endfunction

  task automatic play(input logic [N-1:0] mask, input logic [N*8-1:0] segs);
    build(mask, segs);
    rec8.delete();
    n_done8 = 0;
    bus8.ch_en  = mask;
    bus8.seg_in = segs;
    bus8.start  = 1'b1;
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    // Scramble the live inputs; the snapshot taken at start must shield the run.
    bus8.ch_en  = '1;
    bus8.seg_in = {N{8'h55}};
  endtask

  task automatic wait_idle(input bit sel, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!(sel ? bus4.busy : bus8.busy)) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout: busy still high after %0d cycles", budget);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bus8.en = 1'b1; bus8.start = 1'b0; bus8.ch_en = '0; bus8.seg_in = '1;
    bus4.en = 1'b1; bus4.start = 1'b0; bus4.ch_en = '0; bus4.seg_in = '1;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_morse_out", 32'(bus8.morse_out), 32'd0);
    check("rst_busy",      32'(bus8.busy),      32'd0);
    check("rst_done",      32'(bus8.done),      32'd0);
    check("rst_err",       32'(bus8.err),       32'd0);
    check("rst_code",      32'(bus8.morse_code), 32'd0);
    check("rst_ch",        32'(bus8.cur_ch),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single '1' (.----): dot, then four dashes, unit = 2 cycles.
    play(8'h01, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_idle(1'b0, 200, cyc);
    check_str("one_runs", runs_str(1'b0), "2,2,6,2,6,2,6,2,6");
    check("one_span",   32'(span8()), 32'd34);
    check("one_code",   32'(bus8.morse_code), 32'b01111);
    check("one_done_n", 32'(n_done8), 32'd1);

    // '0' then '2'; the low stretch between them is the 3-unit gap plus the
    // one-cycle slot pick. A start pulse mid-run must be ignored.
    play(8'h03, 64'hFFFF_FFFF_FFFF_A4C0);
    repeat (10) @(posedge clk);
    #1;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    check("busy_after_restart", 32'(bus8.busy), 32'd1);
    wait_idle(1'b0, 300, cyc);
    check_str("two_runs", runs_str(1'b0), "6,2,6,2,6,2,6,2,6,7,2,2,2,2,6,2,6,2,6");
    check("two_ch",     32'(bus8.cur_ch), 32'd1);
    check("two_code",   32'(bus8.morse_code), 32'b00111);
    check("two_done_n", 32'(n_done8), 32'd1);

    // All slots blank: no mark, done after nine pick cycles, no error.
    play(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle(1'b0, 50, cyc);
    check("blank_len", 32'(cyc), 32'd10);
    check_str("blank_runs", runs_str(1'b0), "none");
    check("blank_err", 32'(bus8.err), 32'd0);

    // Unknown pattern in slot 3 sets err.
    play(8'hFF, 64'hFFFF_FFFF_55FF_FFFF);
    wait_idle(1'b0, 50, cyc);
    check("bad_err", 32'(bus8.err), 32'd1);

    // Pause for 5 cycles inside the first dash: that dash grows by 5.
    play(8'h01, 64'hFFFF_FFFF_FFFF_FFF9);
    repeat (6) @(posedge clk);
    #1;
    bus8.en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus8.en = 1'b1;
    wait_idle(1'b0, 200, cyc);
    check_str("pause_runs", runs_str(1'b0), "2,2,11,2,6,2,6,2,6");

    // Reset mid-dash clears the key and busy at once.
    play(8'h01, 64'hFFFF_FFFF_FFFF_FFF9);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_mark", 32'(bus8.morse_out), 32'd1);
    #3;
    rst = 1'b1;
    #2;
    check("rst_mid_mark", 32'(bus8.morse_out), 32'd0);
    check("rst_mid_busy", 32'(bus8.busy), 32'd0);
    h_code = '0;
    h_ch   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    play(8'h01, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_idle(1'b0, 200, cyc);
    check_str("after_rst_runs", runs_str(1'b0), "2,2,6,2,6,2,6,2,6");

    // 4-slot build: only slot 3 = '9' (----.).
    rec4.delete();
    bus4.ch_en  = 4'b1000;
    bus4.seg_in = 32'h90FF_FFFF;
    bus4.start  = 1'b1;
    @(posedge clk);
    #1;
    bus4.start  = 1'b0;
    wait_idle(1'b1, 200, cyc);
    check_str("nine_runs", runs_str(1'b1), "6,2,6,2,6,2,6,2,2");
    check("nine_ch",   32'(bus4.cur_ch), 32'd3);
    check("nine_code", 32'(bus4.morse_code), 32'b11110);
    check("nine_err",  32'(bus4.err), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
